// File: rtl/imem_fetch_arbiter.sv
// Fetch/debug arbiter for the shared instruction-memory read port.
// Optional IMEM_ARB_ALIGN_CHK_EN: misaligned requests return err=1 and a NOP.
module imem_fetch_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int MAX_WAIT = 8,
   parameter int WAIT_W   = $clog2(MAX_WAIT+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req_valid,
   input  logic [ADDR_W-1:0] f_req_addr,
   output logic              f_req_ready,
   output logic              f_resp_valid,
   output logic [31:0]       f_resp_data,
   input  logic              f_resp_ready,
   input  logic              f_flush,
   input  logic              d_req_valid,
   input  logic [ADDR_W-1:0] d_req_addr,
   output logic              d_req_ready,
   output logic              d_resp_valid,
   output logic [31:0]       d_resp_data,
   input  logic              d_resp_ready,
`ifdef IMEM_ARB_ALIGN_CHK_EN
   output logic              f_resp_err,
   output logic              d_resp_err,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [WAIT_W-1:0] d_starve_cnt
);

   localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [31:0]       NOP     = 32'h0000_0013;

   logic              elig_f, elig_d, force_d;
   logic              grant_f, grant_d;
   logic              f_mis, d_mis;
   logic              f_valid_q, f_valid_d;
   logic              d_valid_q, d_valid_d;
   logic [31:0]       f_data_q, f_data_d;
   logic [31:0]       d_data_q, d_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;

`ifdef IMEM_ARB_ALIGN_CHK_EN
   logic f_err_q, f_err_d;
   logic d_err_q, d_err_d;
   assign f_mis = |f_req_addr[1:0];
   assign d_mis = |d_req_addr[1:0];
`else
   assign f_mis = 1'b0;
   assign d_mis = 1'b0;
`endif

   always_comb begin
      elig_f  = f_req_valid & ~f_flush & (~f_valid_q | f_resp_ready);
      elig_d  = d_req_valid & (~d_valid_q | d_resp_ready);
      force_d = elig_d & (cnt_q == CNT_MAX);
      grant_d = force_d | (elig_d & ~elig_f);
      grant_f = elig_f & ~force_d;
   end

   // Misaligned grants leave the memory address untouched.
   always_comb begin
      addr_d = addr_q;
      if (grant_f & ~f_mis) begin
         addr_d = f_req_addr;
      end else if (grant_d & ~d_mis) begin
         addr_d = d_req_addr;
      end
   end

   always_comb begin
      f_valid_d = f_valid_q;
      f_data_d  = f_data_q;
      d_valid_d = d_valid_q;
      d_data_d  = d_data_q;
      if (f_flush) begin
         f_valid_d = 1'b0;
      end else if (grant_f) begin
         f_valid_d = 1'b1;
         f_data_d  = f_mis ? NOP : mem_rdata;
      end else if (f_resp_ready) begin
         f_valid_d = 1'b0;
      end
      if (grant_d) begin
         d_valid_d = 1'b1;
         d_data_d  = d_mis ? NOP : mem_rdata;
      end else if (d_resp_ready) begin
         d_valid_d = 1'b0;
      end
   end

`ifdef IMEM_ARB_ALIGN_CHK_EN
   always_comb begin
      f_err_d = f_err_q;
      d_err_d = d_err_q;
      if (grant_f) f_err_d = f_mis;
      if (grant_d) d_err_d = d_mis;
   end
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (~d_req_valid | grant_d) begin
         cnt_d = '0;
      end else if (elig_d & (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_valid_q <= 1'b0;
         f_data_q  <= '0;
         d_valid_q <= 1'b0;
         d_data_q  <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         f_valid_q <= f_valid_d;
         f_data_q  <= f_data_d;
         d_valid_q <= d_valid_d;
         d_data_q  <= d_data_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef IMEM_ARB_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_err_q <= 1'b0;
         d_err_q <= 1'b0;
      end else begin
         f_err_q <= f_err_d;
         d_err_q <= d_err_d;
      end
   end
   assign f_resp_err = f_err_q;
   assign d_resp_err = d_err_q;
`endif

   assign f_req_ready  = grant_f;
   assign d_req_ready  = grant_d;
   assign f_resp_valid = f_valid_q;
   assign f_resp_data  = f_data_q;
   assign d_resp_valid = d_valid_q;
   assign d_resp_data  = d_data_q;
   assign mem_addr     = addr_d;
   assign d_starve_cnt = cnt_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed scenarios then random traffic
// checked against a transaction-level reference model.
module tb_imem_fetch_arbiter;

   localparam int ADDR_W   = 64;
   localparam int MAX_WAIT = 8;
   localparam int WAIT_W   = $clog2(MAX_WAIT+1);

   logic              clk;
   logic              rst_n;
   logic              f_req_valid, f_req_ready, f_resp_valid, f_resp_ready, f_flush;
   logic              d_req_valid, d_req_ready, d_resp_valid, d_resp_ready;
   logic [ADDR_W-1:0] f_req_addr, d_req_addr, mem_addr;
   logic [31:0]       f_resp_data, d_resp_data, mem_rdata;
   logic [WAIT_W-1:0] d_starve_cnt;
`ifdef IMEM_ARB_ALIGN_CHK_EN
   logic              f_resp_err, d_resp_err;
`endif

   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];

   imem_fetch_arbiter #(
      .ADDR_W(ADDR_W),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .f_req_valid(f_req_valid),
      .f_req_addr(f_req_addr),
      .f_req_ready(f_req_ready),
      .f_resp_valid(f_resp_valid),
      .f_resp_data(f_resp_data),
      .f_resp_ready(f_resp_ready),
      .f_flush(f_flush),
      .d_req_valid(d_req_valid),
      .d_req_addr(d_req_addr),
      .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid),
      .d_resp_data(d_resp_data),
      .d_resp_ready(d_resp_ready),
`ifdef IMEM_ARB_ALIGN_CHK_EN
      .f_resp_err(f_resp_err),
      .d_resp_err(d_resp_err),
`endif
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata),
      .d_starve_cnt(d_starve_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // Reference model: outstanding response per port, D's wait count
   // and the last address presented to memory.
   bit          m_fv, m_dv, m_fe, m_de;
   logic [31:0] m_fd, m_dd;
   int          m_wait;
   logic [63:0] m_addr;
   bit          n_fv, n_dv, n_fe, n_de;
   logic [31:0] n_fd, n_dd;
   int          n_wait;
   logic [63:0] n_addr;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fv = 0; m_dv = 0; m_fe = 0; m_de = 0;
      m_fd = '0; m_dd = '0; m_wait = 0; m_addr = '0;
   endtask

   function automatic bit misaligned(input logic [63:0] a);
`ifdef IMEM_ARB_ALIGN_CHK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] word_at(input logic [63:0] a);
      logic [7:0] idx;
      idx = a[9:2];
      return misaligned(a) ? 32'h0000_0013 : mem[idx];
   endfunction

   // Check the current cycle against the model and compute the next state.
   task automatic pre();
      bit          can_f, can_d, win_f, win_d;
      logic [63:0] exp_addr;
      #2;
      can_f = f_req_valid && !f_flush && (!m_fv || f_resp_ready);
      can_d = d_req_valid && (!m_dv || d_resp_ready);
      win_d = can_d && (m_wait >= MAX_WAIT || !can_f);
      win_f = can_f && !win_d;
      exp_addr = m_addr;
      if (win_f && !misaligned(f_req_addr)) exp_addr = f_req_addr;
      if (win_d && !misaligned(d_req_addr)) exp_addr = d_req_addr;
      chk("f_req_ready", f_req_ready, win_f);
      chk("d_req_ready", d_req_ready, win_d);
      chk("mem_addr", mem_addr, exp_addr);
      chk("f_resp_valid", f_resp_valid, m_fv);
      chk("d_resp_valid", d_resp_valid, m_dv);
      chk("f_resp_data", f_resp_data, m_fd);
      chk("d_resp_data", d_resp_data, m_dd);
      chk("d_starve_cnt", d_starve_cnt, m_wait);
`ifdef IMEM_ARB_ALIGN_CHK_EN
      chk("f_resp_err", f_resp_err, m_fe);
      chk("d_resp_err", d_resp_err, m_de);
`endif
      n_fv = m_fv; n_fd = m_fd; n_fe = m_fe;
      n_dv = m_dv; n_dd = m_dd; n_de = m_de;
      if (f_flush) n_fv = 0;
      else if (win_f) begin
         n_fv = 1; n_fd = word_at(f_req_addr); n_fe = misaligned(f_req_addr);
      end else if (f_resp_ready) n_fv = 0;
      if (win_d) begin
         n_dv = 1; n_dd = word_at(d_req_addr); n_de = misaligned(d_req_addr);
      end else if (d_resp_ready) n_dv = 0;
      if (!d_req_valid || win_d) n_wait = 0;
      else if (can_d) n_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else n_wait = m_wait;
      n_addr = exp_addr;
   endtask

   task automatic post();
      @(posedge clk);
      m_fv = n_fv; m_fd = n_fd; m_fe = n_fe;
      m_dv = n_dv; m_dd = n_dd; m_de = n_de;
      m_wait = n_wait; m_addr = n_addr;
      @(negedge clk);
   endtask

   task automatic cyc();
      pre();
      post();
   endtask

   initial begin
      rst_n = 0;
      f_req_valid = 0; f_req_addr = '0; f_resp_ready = 0; f_flush = 0;
      d_req_valid = 0; d_req_addr = '0; d_resp_ready = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[4] = 32'h0050_0093;
      mem[8] = 32'hDEAD_BEEF;
      model_reset();

      // Reset state
      #3;
      chk("rst_f_valid", f_resp_valid, 1'b0);
      chk("rst_d_valid", d_resp_valid, 1'b0);
      chk("rst_f_data", f_resp_data, 32'h0);
      chk("rst_d_data", d_resp_data, 32'h0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_cnt", d_starve_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;

      // Single fetch
      f_req_valid = 1; f_req_addr = 64'h10; f_resp_ready = 1;
      pre();
      chk("single_rdy", f_req_ready, 1'b1);
      chk("single_addr", mem_addr, 64'h10);
      post();
      f_req_valid = 0;
      pre();
      chk("single_valid", f_resp_valid, 1'b1);
      chk("single_data", f_resp_data, 32'h0050_0093);
      post();

      // Back-to-back fetches
      f_req_valid = 1;
      for (int i = 0; i < 3; i++) begin
         f_req_addr = 64'(4 * i);
         pre();
         chk("b2b_rdy", f_req_ready, 1'b1);
         post();
      end
      f_req_valid = 0;
      cyc();

      // Reset mid-stream, asynchronous
      f_req_valid = 1; f_req_addr = 64'h10; f_resp_ready = 0;
      cyc();
      f_req_valid = 0;
      pre();
      #1 rst_n = 0;
      #1;
      chk("arst_f_valid", f_resp_valid, 1'b0);
      chk("arst_d_valid", d_resp_valid, 1'b0);
      chk("arst_cnt", d_starve_cnt, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      f_resp_ready = 1;

      // Contention with starvation guard
      f_req_valid = 1; f_req_addr = 64'h40;
      d_req_valid = 1; d_req_addr = 64'h80;
      d_resp_ready = 1;
      for (int i = 0; i < 10; i++) begin
         pre();
         chk("cont_d_gnt", d_req_ready, i == 8);
         chk("cont_f_gnt", f_req_ready, i != 8);
         chk("cont_cnt", d_starve_cnt, (i <= 8) ? i : 0);
         post();
      end
      f_req_valid = 0; d_req_valid = 0;
      cyc();

      // Backpressure on F
      f_req_valid = 1; f_req_addr = 64'h20; f_resp_ready = 0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         pre();
         chk("bp_blocked", f_req_ready, 1'b0);
         chk("bp_hold", f_resp_data, 32'hDEAD_BEEF);
         post();
      end
      f_resp_ready = 1;
      pre();
      chk("bp_release", f_req_ready, 1'b1);
      post();
      f_req_valid = 0;
      cyc();

      // Flush while D requests
      f_req_valid = 1; f_req_addr = 64'h10; f_resp_ready = 0;
      cyc();
      f_flush = 1; d_req_valid = 1; d_req_addr = 64'h6; d_resp_ready = 0;
      pre();
      chk("flush_no_f", f_req_ready, 1'b0);
      chk("flush_d_gnt", d_req_ready, 1'b1);
      post();
      f_flush = 0; f_req_valid = 0; d_req_valid = 0;
      pre();
      chk("flush_f_gone", f_resp_valid, 1'b0);
      chk("flush_d_resp", d_resp_valid, 1'b1);
`ifdef IMEM_ARB_ALIGN_CHK_EN
      chk("flush_d_err", d_resp_err, 1'b1);
      chk("flush_d_nop", d_resp_data, 32'h0000_0013);
`endif
      post();
      d_resp_ready = 1; f_resp_ready = 1;
      cyc();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         f_req_valid  = ($urandom_range(9) < 7);
         d_req_valid  = ($urandom_range(9) < 5);
         f_resp_ready = ($urandom_range(9) < 6);
         d_resp_ready = ($urandom_range(9) < 6);
         f_flush      = ($urandom_range(9) == 0);
         f_req_addr   = {$urandom, $urandom};
         d_req_addr   = {$urandom, $urandom};
         if ($urandom_range(3) != 0) f_req_addr[1:0] = 2'b00;
         if ($urandom_range(3) != 0) d_req_addr[1:0] = 2'b00;
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares the single combinational read port of the byte-addressable instruction memory between two requesters: the pipeline fetch stage (port F) and the debug/program-inspection port (port D).
- Registers the 32-bit little-endian instruction word returned by the memory, giving each port a one-cycle-latency valid/ready response channel.
- Arbitration is fixed priority to F, with a starvation guard for D.
- Supports a fetch flush on branch redirect.

Parameters:
- ADDR_W, 64, request/memory address width in bits.
- MAX_WAIT, 8, consecutive cycles D may be eligible-but-denied before it is forced a grant; legal range 1..255.
- WAIT_W, $clog2(MAX_WAIT+1), width of the starvation counter (derived; never overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req_valid  in  1  fetch request valid.
- f_req_addr  in  ADDR_W  fetch byte address.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_resp_valid  out  1  fetch response valid.
- f_resp_data  out  32  fetch instruction word.
- f_resp_ready  in  1  fetch response consumed.
- f_flush  in  1  drop any pending and accepted-this-cycle fetch response.
- d_req_valid / d_req_addr / d_req_ready  same as the F equivalents, debug port.
- d_resp_valid / d_resp_data / d_resp_ready  same as the F equivalents, debug port.
- mem_addr  out  ADDR_W  address to the instruction memory.
- mem_rdata  in  32  combinational instruction word from memory.
- d_starve_cnt  out  WAIT_W  current starvation count (debug visibility).

Behaviour:
- Reset (rst_n=0, asynchronous): f_resp_valid=0, d_resp_valid=0, f_resp_data=0, d_resp_data=0, mem_addr=0, starvation counter=0. Reset mid-transaction discards all in-flight responses.
- Eligibility is combinational:
  - elig_F = f_req_valid & ~f_flush & (~f_resp_valid | f_resp_ready).
  - elig_D = d_req_valid & (~d_resp_valid | d_resp_ready).
  - A port holding an unconsumed response is blocked; pass-through is allowed in the cycle that response is consumed.
- Grant (at most one per cycle):
  - force_D = elig_D & (cnt == MAX_WAIT).
  - grant_D = force_D | (elig_D & ~elig_F).
  - grant_F = elig_F & ~force_D.
- Ready outputs: f_req_ready = grant_F; d_req_ready = grant_D. A ready is never asserted without the matching valid.
- Memory address:
  - mem_addr is combinational: the granted port's address in the grant cycle.
  - With no grant, mem_addr holds its last registered granted address; the register updates on grant.
  - mem_rdata is sampled in the same cycle it is driven.
- Response timing:
  - On grant in cycle N, p_resp_data <= mem_rdata and p_resp_valid <= 1 at the edge ending cycle N, so the response is valid in cycle N+1.
  - Data is held stable while p_resp_valid & ~p_resp_ready.
  - p_resp_valid clears on p_resp_ready unless a new grant to that port occurs in the same cycle; in that case valid stays 1 and data is replaced.
- Throughput: a port whose consumer holds resp_ready=1 may be granted every cycle (1 word/cycle).
- Starvation counter:
  - Increments (saturating at MAX_WAIT) each cycle elig_D & ~grant_D.
  - Clears on grant_D or when d_req_valid=0.
- Flush:
  - f_flush=1 clears f_resp_valid at the next edge, regardless of f_resp_ready.
  - Blocks grant_F in that cycle, so D may be granted instead.
  - Does not touch the D channel.
- Simultaneous f_flush and f_resp_ready: the flush wins; no new F response appears.
- Addresses pass unmodified. Alignment is the requester's responsibility unless the optional feature is enabled. Out-of-range wrap is handled by the memory.

Optional Feature:
- Macro: IMEM_ARB_ALIGN_CHK_EN.
- Defined:
  - Adds outputs f_resp_err and d_resp_err (1 bit each, reset 0), registered alongside the response data.
  - A granted request with addr[1:0] != 0 still completes the handshake and arbitration, but the response has err=1 and data=32'h0000_0013 (NOP).
  - mem_addr is not updated for that grant.
- Undefined: the err ports do not exist; misaligned addresses are forwarded to memory unchanged.

Test Plan:
- Reset mid-stream: assert rst_n=0 asynchronously while f_resp_valid=1 -> f_resp_valid, d_resp_valid and counter drop to 0 immediately, before the next clk edge.
- Single fetch: f_req_valid=1, addr=0x10, memory returns 0x00500093 -> f_req_ready=1 in cycle N; f_resp_valid=1 with data 0x00500093 in N+1.
- Back-to-back: F requests 0x0,0x4,0x8 with f_resp_ready=1 -> three grants in consecutive cycles; responses in N+1..N+3 in order.
- Contention and starvation, MAX_WAIT=8: F and D both valid continuously -> F granted 8 cycles, D granted on cycle 9 (d_starve_cnt=8 then 0), F granted again on cycle 10.
- Backpressure: f_resp_ready=0 with response 0xDEADBEEF held -> f_req_ready=0 and data stable for 5 cycles; raising f_resp_ready with f_req_valid=1 gives a same-cycle grant.
- Flush: f_flush=1 while f_resp_valid=1 and D requesting -> f_resp_valid=0 next cycle, no F grant that cycle, D granted; with IMEM_ARB_ALIGN_CHK_EN, D addr=0x6 -> d_resp_err=1, data=0x00000013.
